// File: rtl/maple_tx_if.sv
// rtl/maple_tx_if.sv - host, FIFO and line-driver signals of the Maple TX sequencer
interface maple_tx_if;
  logic       tx_go;
  logic [7:0] tx_len;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] fifo_data;
  logic       fifo_avail;
  logic       fifo_consume;
  logic       tick;
  logic       mo_trigger_start;
  logic       mo_trigger_end;
  logic       mo_start_active;
  logic       mo_oe;
  logic [7:0] mo_data;
  logic       mo_avail;
  logic       mo_consume;

  modport master (
    input  tx_go, tx_len, fifo_data, fifo_avail, mo_start_active, mo_oe, mo_consume,
    output busy, done, err, fifo_consume, tick, mo_trigger_start, mo_trigger_end,
           mo_data, mo_avail
  );

  modport slave (
    output tx_go, tx_len, fifo_data, fifo_avail, mo_start_active, mo_oe, mo_consume,
    input  busy, done, err, fifo_consume, tick, mo_trigger_start, mo_trigger_end,
           mo_data, mo_avail
  );
endinterface

// File: rtl/maple_tx_ctrl.sv
// rtl/maple_tx_ctrl.sv - Maple bus TX packet sequencer; MAPLE_TX_CRC_EN appends an XOR check byte
module maple_tx_ctrl #(
  parameter int TICK_DIV    = 4,
  parameter int STALL_TICKS = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  maple_tx_if.master io_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
`ifdef MAPLE_TX_CRC_EN
    S_CRC,
`endif
    S_DRAIN,
    S_END,
    S_DONE
  } state_t;

`ifdef MAPLE_TX_CRC_EN
  localparam state_t S_POST = S_CRC;
`else
  localparam state_t S_POST = S_DRAIN;
`endif

  localparam logic [7:0] TICK_LAST  = 8'(TICK_DIV - 1);
  localparam logic [7:0] STALL_LAST = 8'(STALL_TICKS - 1);
  localparam logic [5:0] DRAIN_FULL = 6'd32;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_div;
  logic [7:0] r_rem;
  logic [5:0] r_drain;
  logic [7:0] r_stall;
  logic       r_abort;
  logic       r_sent;
  logic       r_trig_start;
`ifdef MAPLE_TX_CRC_EN
  logic [7:0] r_crc;
`endif

  logic       w_go;
  logic       w_tick;
  logic       w_stall_hit;
  logic [5:0] w_drain_inc;
  logic [7:0] w_mo_data;
  logic       w_mo_avail;
  logic       w_fifo_consume;
  logic       w_trig_end;

  assign w_go        = (r_state == S_IDLE) && io_bus.tx_go;
  assign w_tick      = (r_div == TICK_LAST);
  assign w_drain_inc = (r_drain == DRAIN_FULL) ? DRAIN_FULL : r_drain + 6'd1;
  assign w_stall_hit = w_tick && !io_bus.fifo_avail && (r_stall == STALL_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_mo_data      = 8'h00;
    w_mo_avail     = 1'b0;
    w_fifo_consume = 1'b0;
    w_trig_end     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.tx_go) w_next = (io_bus.tx_len == 8'd0) ? S_POST : S_DATA;
      end
      S_DATA: begin
        w_mo_data      = io_bus.fifo_data;
        w_mo_avail     = io_bus.fifo_avail;
        w_fifo_consume = io_bus.mo_consume;
        if (io_bus.mo_consume) begin
          if (r_rem == 8'd1) w_next = S_POST;
        end else if (w_stall_hit) begin
          w_next = S_DRAIN;
        end
      end
`ifdef MAPLE_TX_CRC_EN
      S_CRC: begin
        w_mo_data  = r_crc;
        w_mo_avail = 1'b1;
        if (io_bus.mo_consume) w_next = S_DRAIN;
      end
`endif
      S_DRAIN: begin
        // The last byte is on the wire until 32 ticks have passed since it was taken.
        if ((r_drain == DRAIN_FULL) && !io_bus.mo_start_active) begin
          w_trig_end = 1'b1;
          w_next     = S_END;
        end
      end
      S_END: begin
        if (!io_bus.mo_oe) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_div        <= 8'd0;
      r_rem        <= 8'd0;
      r_drain      <= 6'd0;
      r_stall      <= 8'd0;
      r_abort      <= 1'b0;
      r_sent       <= 1'b0;
      r_trig_start <= 1'b0;
`ifdef MAPLE_TX_CRC_EN
      r_crc        <= 8'h00;
`endif
    end else begin
      r_trig_start <= w_go;
      if (w_go || w_tick) r_div <= 8'd0;
      else                r_div <= r_div + 8'd1;

      if (w_go) begin
        r_rem   <= io_bus.tx_len;
        r_stall <= 8'd0;
        r_abort <= 1'b0;
        r_sent  <= 1'b0;
        // An empty packet has nothing to shift out, so drain starts satisfied.
        r_drain <= (io_bus.tx_len == 8'd0) ? DRAIN_FULL : 6'd0;
`ifdef MAPLE_TX_CRC_EN
        r_crc   <= 8'h00;
`endif
      end else begin
        case (r_state)
          S_DATA: begin
            if (io_bus.mo_consume) begin
              r_rem   <= r_rem - 8'd1;
              r_stall <= 8'd0;
              r_drain <= 6'd0;
              r_sent  <= 1'b1;
`ifdef MAPLE_TX_CRC_EN
              r_crc   <= r_crc ^ io_bus.fifo_data;
`endif
            end else if (w_tick) begin
              r_drain <= w_drain_inc;
              if (!io_bus.fifo_avail) r_stall <= r_stall + 8'd1;
              if (w_stall_hit) begin
                r_abort <= 1'b1;
                if (!r_sent) r_drain <= DRAIN_FULL;
              end
            end
          end
`ifdef MAPLE_TX_CRC_EN
          S_CRC: begin
            if (io_bus.mo_consume) r_drain <= 6'd0;
            else if (w_tick)       r_drain <= w_drain_inc;
          end
`endif
          S_DRAIN: begin
            if (w_tick) r_drain <= w_drain_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign io_bus.busy             = (r_state != S_IDLE);
  assign io_bus.done             = (r_state == S_DONE);
  assign io_bus.err              = (r_state == S_DONE) && r_abort;
  assign io_bus.fifo_consume     = w_fifo_consume;
  assign io_bus.tick             = w_tick;
  assign io_bus.mo_trigger_start = r_trig_start;
  assign io_bus.mo_trigger_end   = w_trig_end;
  assign io_bus.mo_data          = w_mo_data;
  assign io_bus.mo_avail         = w_mo_avail;

endmodule

// File: doc/maple_tx_ctrl.md
# maple_tx_ctrl

Packet-level transmit sequencer for the Maple bus line driver. It generates the bit-rate tick and issues the start trigger, then streams a programmed number of payload bytes from the upstream TX FIFO into the driver's byte port. It can append an XOR check byte, then issues the end trigger once the last byte has fully shifted out. It sits between the host-side TX FIFO and the line driver and reports completion, FIFO-underrun abort and busy status to the host register block.

## Interface
Parameters:
- TICK_DIV, 4: clocks per bit-rate tick; legal range 2..256.
- STALL_TICKS, 64: consecutive empty-FIFO ticks in DATA before abort; legal range 1..255.

Ports:
- clk  in  1  system clock, one clock domain.
- rst  in  1  asynchronous, active-low reset.
- tx_go  in  1  single-cycle request to send a packet; honoured only in IDLE.
- tx_len  in  8  payload byte count, sampled with tx_go; 0 is legal.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the packet is finished.
- err  out  1  valid with done; 1 means the packet was aborted on underrun.
- fifo_data  in  8  upstream FIFO head byte.
- fifo_avail  in  1  upstream FIFO non-empty.
- fifo_consume  out  1  pops the upstream FIFO.
- tick  out  1  bit-rate strobe to the driver.
- mo_trigger_start  out  1  driver start-pattern trigger, one-cycle pulse.
- mo_trigger_end  out  1  driver end-pattern trigger, one-cycle pulse.
- mo_start_active  in  1  driver is emitting the start pattern.
- mo_oe  in  1  driver output enable.
- mo_data  out  8  byte presented to the driver.
- mo_avail  out  1  byte valid to the driver.
- mo_consume  in  1  driver accepted mo_data this cycle.

## Operation
States: IDLE, DATA, CRC, DRAIN, END, DONE.
- **IDLE**
  - On tx_go: latch rem = tx_len, clear crc to 0x00, clear drain and stall counters, reset the tick divider to 0.
  - Pulse mo_trigger_start for one cycle and go to DATA. If tx_len == 0, go directly to CRC or DRAIN instead, per configuration.
- **DATA**
  - Pass-through: mo_data = fifo_data, mo_avail = fifo_avail, fifo_consume = mo_consume.
  - On mo_consume: rem decrements and crc ^= fifo_data.
  - When rem reaches 0 on a consume: go to CRC if enabled, otherwise DRAIN. The drain counter restarts on that consume.
- **CRC**
  - mo_data = crc, mo_avail = 1, fifo_consume = 0.
  - On mo_consume: restart the drain counter and go to DRAIN.
- **DRAIN**
  - mo_avail = 0. The drain counter counts ticks, saturating at 32.
  - When drain == 32 and mo_start_active == 0: pulse mo_trigger_end and go to END.
  - For a packet with zero bytes sent, drain is preset to 32, so only start_active gates the exit.
- **END**: wait for mo_oe == 0, then go to DONE.
- **DONE**: done = 1 for one cycle, err = abort flag; then go to IDLE.
- **Stall abort**
  - In DATA, each tick with fifo_avail == 0 increments the stall counter; any consume clears it.
  - When the counter reaches STALL_TICKS: set the abort flag and go to DRAIN. Drain is preset to 32 if no byte has been consumed yet, otherwise the running value is kept.
  - Unsent FIFO bytes are left in place for the host to flush.
- In IDLE, DRAIN, END and DONE: fifo_consume = 0 and mo_avail = 0.
- tx_go outside IDLE is ignored, including in the DONE cycle.

## Timing
- Reset values: every output is 0, and the state is IDLE.
  - Reset is asynchronous: outputs go to 0 as soon as rst asserts, mid-packet included.
  - rst must be shared with the driver so the two do not desynchronise.
- tick is a one-cycle strobe when the divider equals TICK_DIV-1. It is free-running, and its first strobe comes TICK_DIV cycles after tx_go.
- Handshake timing:
  - mo_trigger_start is asserted the cycle after tx_go.
  - fifo_consume is combinational from mo_consume, with zero latency.
  - rem and crc update on the clock edge of the consume cycle.
- A tick in the consume cycle is not counted. The end trigger comes no earlier than the clock after the 32nd subsequent tick, which covers the full 32-tick byte shift.
- done is asserted 1 cycle after mo_oe is observed low in END.

## Configuration
- MAPLE_TX_CRC_EN defined:
  - The CRC state is present; one check byte (XOR of all payload bytes, initial value 0x00) is appended after the payload.
  - A tx_len = 0 packet sends a single 0x00 byte.
- MAPLE_TX_CRC_EN undefined:
  - The CRC state and the crc register are removed; only the payload is sent.
  - A tx_len = 0 packet sends the start pattern, then the end pattern, with no bytes.

## Test plan
- CRC on, tx_len=2, FIFO holds 0x12,0x34 -> three driver consumes: 0x12, 0x34, then 0x26 with fifo_consume=0. trigger_end follows 32 ticks after the third consume; done=1 and err=0 after mo_oe falls.
- CRC off, tx_len=0 -> trigger_start, no fifo_consume, trigger_end the cycle after mo_start_active falls, then done.
- STALL_TICKS=64, FIFO empties after 1 of 4 bytes -> 64 empty ticks, then drain completes, trigger_end, done with err=1; 3 bytes are still in the FIFO.
- tx_go pulsed mid-DATA and again in the DONE cycle -> ignored: no second trigger_start, rem unchanged.
- rst asserted during DATA -> all outputs are 0 immediately and the state is IDLE; a fresh tx_go then sends a complete packet.
- TICK_DIV=4 -> tick on cycles 4, 8, 12, … after tx_go, each one cycle wide.
